// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port 32-bit word front end sequencing 4-byte bursts onto the PSRAM byte handshake
module psram_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_mem,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        mem_rend,
  output logic        mem_wend,
  output logic [23:0] mem_a,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_byte_available,
  input  logic        mem_ready_for_next_byte,
  input  logic        mem_ready
);
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RD_DATA, WR_DATA, WAIT_DONE, ACK} state_t;
  state_t      state_q, state_d;
  logic        port_q, port_d, wr_q, wr_d, last_q, last_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d, buf_q, buf_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d, rd_q, rd_d, we_q, we_d;
  logic        rend_q, rend_d, wend_q, wend_d;
  logic [23:0] a_q, a_d;
  logic [7:0]  din_q, din_d, dout_q;
  logic        ba_q, ba2_q, rn_q, rn2_q;
  logic        g, we_g, ba_rise, rn_rise;
  logic [23:0] addr_g;
  logic [31:0] wdata_g;
  // on a tie, round-robin favours the port not served last
  assign g       = req0 ? (req1 & ~FIXED_PRIO & ~last_q) : 1'b1;
  assign we_g    = g ? we1 : we0;
  assign addr_g  = g ? addr1 : addr0;
  assign wdata_g = g ? wdata1 : wdata0;
  assign ba_rise = ba_q & ~ba2_q;
  assign rn_rise = rn_q & ~rn2_q;
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    wr_d     = wr_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rend_d   = rend_q;
    wend_d   = wend_q;
    a_d      = a_q;
    din_d    = din_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rd_d     = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      IDLE: if (mem_ready && (req0 || req1)) begin
        port_d  = g;
        wr_d    = we_g;
        a_d     = addr_g & 24'hFFFFFC;
        wdata_d = wdata_g;
        din_d   = we_g ? wdata_g[7:0] : din_q;
        rd_d    = ~we_g;
        we_d    = we_g;
        cnt_d   = 2'd0;
        state_d = START;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = mem_ready ? WAIT_BUSY : (wr_q ? WR_DATA : RD_DATA);
      RD_DATA: if (ba_rise) begin
        buf_d[{cnt_q, 3'b000} +: 8] = dout_q;
        cnt_d   = cnt_q + 2'd1;
        rend_d  = rend_q | (cnt_q == 2'd2);
        state_d = (cnt_q == 2'd3) ? WAIT_DONE : RD_DATA;
      end
      WR_DATA: if (rn_rise) begin
        din_d   = wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
        cnt_d   = cnt_q + 2'd1;
        wend_d  = cnt_q == 2'd2;
        state_d = (cnt_q == 2'd2) ? WAIT_DONE : WR_DATA;
      end
      WAIT_DONE: if (mem_ready) begin
        rend_d   = 1'b0;
        wend_d   = 1'b0;
        ack0_d   = ~port_q;
        ack1_d   = port_q;
        rdata0_d = (!wr_q && !port_q) ? buf_q : rdata0_q;
        rdata1_d = (!wr_q && port_q) ? buf_q : rdata1_q;
        state_d  = ACK;
      end
      ACK: begin
        last_d  = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_mem) begin
    if (rst) begin
      state_q  <= IDLE;
      {port_q, wr_q, cnt_q, ack0_q, ack1_q, rd_q, we_q, rend_q, wend_q} <= '0;
      last_q   <= 1'b1;
      {wdata_q, buf_q, rdata0_q, rdata1_q} <= '0;
      {a_q, din_q, dout_q} <= '0;
      {ba_q, ba2_q, rn_q, rn2_q} <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      rend_q   <= rend_d;
      wend_q   <= wend_d;
      a_q      <= a_d;
      din_q    <= din_d;
      dout_q   <= mem_dout;
      ba_q     <= mem_byte_available;
      ba2_q    <= ba_q;
      rn_q     <= mem_ready_for_next_byte;
      rn2_q    <= rn_q;
    end
  end
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = state_q != IDLE;
  assign mem_rd   = rd_q;
  assign mem_we   = we_q;
  assign mem_rend = rend_q;
  assign mem_wend = wend_q;
  assign mem_a    = a_q;
  assign mem_din  = din_q;
endmodule
